// File: rtl/ts_tx_serializer_if.sv
// Ordered-set handshake bundle between the TS generator, this serializer and the lane encoder.
// Latency: none, wires only.
// Backpressure: ts_tx_fifo_full toward the generator, tx_ready from the encoder.
interface ts_tx_serializer_if;
    logic         ts_valid;
    logic [127:0] ts;
    logic         ts_tx_fifo_full;
    logic         flush;
    logic         tx_ready;
    logic         tx_valid;
    logic [7:0]   tx_symbol;
    logic         tx_k;
    logic [15:0]  ts_sent_cnt;
    logic         overflow;

    // Generator/encoder side drives the inputs of the serializer.
    modport master (
        output ts_valid, ts, flush, tx_ready,
        input  ts_tx_fifo_full, tx_valid, tx_symbol, tx_k, ts_sent_cnt, overflow
    );

    // Serializer side.
    modport slave (
        input  ts_valid, ts, flush, tx_ready,
        output ts_tx_fifo_full, tx_valid, tx_symbol, tx_k, ts_sent_cnt, overflow
    );
endinterface

// File: rtl/ts_tx_serializer.sv
// Buffers 128-bit ordered sets and emits them one 8-bit symbol per accepted cycle, tagging K symbols.
// Latency: write at cycle N -> count at N+1 -> symbol 0 on tx_valid at N+2; back-to-back sets have no bubble.
// Backpressure: tx_ready low freezes the current symbol; full raised FULL_MARGIN entries early, writes at DEPTH dropped.
module ts_tx_serializer #(
    parameter int         DEPTH       = 4,
    parameter int         FULL_MARGIN = 1,
    parameter logic [7:0] COM_SYM     = 8'hBC,
    parameter logic [7:0] PAD_SYM     = 8'hF7
) (
    input  logic               clk,
    input  logic               rst,
    ts_tx_serializer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_HI   = CW'(DEPTH - FULL_MARGIN);

    typedef enum logic {IDLE, SEND} state_t;

    logic [127:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow_r;

    state_t        state;
    state_t        state_nxt;
    logic [127:0]  shift_reg;
    logic [3:0]    idx;
    logic [15:0]   sent_cnt;

    logic          fifo_nonempty;
    logic          wr_en;
    logic          pop;
    logic          advance;
    logic          done;
    logic [7:0]    cur_sym;

    assign fifo_nonempty = (count != '0);
    // A flush cycle drops the concurrent write; a write into a full FIFO is dropped too.
    assign wr_en         = bus.ts_valid && !bus.flush && (count != CNT_FULL);
    assign cur_sym       = shift_reg[127:120];

    // Next-state and control: pop the head whenever a new set is started, including at the end of a set.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        advance   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_nonempty) begin
                    pop       = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (bus.tx_ready) begin
                    advance = 1'b1;
                    if (idx == 4'd15) begin
                        done = 1'b1;
                        if (fifo_nonempty) begin
                            pop = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Storage array; not reset since count gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= bus.ts;
        end
    end

    // FIFO pointers, occupancy and sticky overflow; flush empties the queue but a same-cycle pop still loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (bus.flush) begin
                count  <= '0;
                rd_ptr <= wr_ptr;
            end else begin
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count + CW'(wr_en) - CW'(pop);
            end
            if (bus.ts_valid && !bus.flush && (count == CNT_FULL)) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Shift register, symbol index and completion counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            idx       <= '0;
            sent_cnt  <= '0;
        end else begin
            if (pop) begin
                shift_reg <= mem[rd_ptr];
                idx       <= '0;
            end else if (advance) begin
                shift_reg <= {shift_reg[119:0], 8'h00};
                idx       <= idx + 4'd1;
            end
            if (done) begin
                sent_cnt <= sent_cnt + 16'd1;
            end
        end
    end

    // Outputs depend on registers only, so a stall holds them stable.
    always_comb begin
        bus.tx_valid        = (state == SEND);
        bus.tx_symbol       = (state == SEND) ? cur_sym : 8'h00;
        bus.tx_k            = (state == SEND) &&
                              (((idx == 4'd0) && (cur_sym == COM_SYM)) ||
                               (((idx == 4'd1) || (idx == 4'd2)) && (cur_sym == PAD_SYM)));
        bus.ts_tx_fifo_full = (count >= CNT_HI);
        bus.ts_sent_cnt     = sent_cnt;
        bus.overflow        = overflow_r;
    end
endmodule

// File: tb/tb_ts_tx_serializer.sv
// Directed bench for ts_tx_serializer: one task per scenario, inline comparisons.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
// Backpressure scenarios use DEPTH=4, FULL_MARGIN=1.
module tb_ts_tx_serializer;
    logic clk = 1'b0;
    logic rst;
    int   nvec = 0;
    int   nerr = 0;
    int   exp_sent = 0;

    ts_tx_serializer_if bus();

    ts_tx_serializer #(
        .DEPTH(4), .FULL_MARGIN(1), .COM_SYM(8'hBC), .PAD_SYM(8'hF7)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mk_set(input logic [3:0] hi);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[127-8*i -: 8] = {hi, 4'(i)};
        return v;
    endfunction

    function automatic logic [7:0] sym_of(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.ts_valid = 1'b0; bus.ts = '0; bus.flush = 1'b0; bus.tx_ready = 1'b0;
        step(); step(); step();
        rst = 1'b0;
        step();
        nvec++; if (bus.tx_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b want 0", bus.tx_valid); end
        nvec++; if (bus.tx_symbol !== 8'h00) begin nerr++; $display("FAIL reset_symbol got %h want 00", bus.tx_symbol); end
        nvec++; if (bus.tx_k !== 1'b0) begin nerr++; $display("FAIL reset_k got %b want 0", bus.tx_k); end
        nvec++; if (bus.ts_tx_fifo_full !== 1'b0) begin nerr++; $display("FAIL reset_full got %b want 0", bus.ts_tx_fifo_full); end
        nvec++; if (bus.ts_sent_cnt !== 16'd0) begin nerr++; $display("FAIL reset_cnt got %0d want 0", bus.ts_sent_cnt); end
        nvec++; if (bus.overflow !== 1'b0) begin nerr++; $display("FAIL reset_ovf got %b want 0", bus.overflow); end
    endtask

    task automatic test_single_set();
        logic [127:0] s;
        logic [15:0]  kmask;
        s = {8'hBC, 8'hF7, 8'hF7, 8'hFF, 8'h02, 8'h00, {10{8'h4A}}};
        kmask = 16'h0007;
        bus.tx_ready = 1'b1;
        bus.ts = s; bus.ts_valid = 1'b1;
        step();
        bus.ts_valid = 1'b0;
        nvec++; if (bus.tx_valid !== 1'b0) begin nerr++; $display("FAIL single_latency_n1 got valid=%b want 0", bus.tx_valid); end
        step();
        for (int i = 0; i < 16; i++) begin
            nvec++;
            if (bus.tx_valid !== 1'b1 || bus.tx_symbol !== sym_of(s, i) || bus.tx_k !== kmask[i]) begin
                nerr++;
                $display("FAIL single_sym%0d got v=%b s=%h k=%b want v=1 s=%h k=%b",
                         i, bus.tx_valid, bus.tx_symbol, bus.tx_k, sym_of(s, i), kmask[i]);
            end
            step();
        end
        exp_sent++;
        nvec++; if (bus.tx_valid !== 1'b0) begin nerr++; $display("FAIL single_end_valid got %b want 0", bus.tx_valid); end
        nvec++; if (bus.ts_sent_cnt !== 16'(exp_sent)) begin nerr++; $display("FAIL single_cnt got %0d want %0d", bus.ts_sent_cnt, exp_sent); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] sets [3];
        logic [15:0]  kmask [3];
        int cyc, p, si, i;
        logic ev;
        sets[0] = {8'hBC, 8'hF7, 8'hF7, 8'hFF, 8'h02, 8'h00, {10{8'h4A}}};
        sets[1] = {8'hF7, 8'hBC, 8'hBC, 8'hF7, {12{8'h55}}};
        sets[2] = {8'hBC, 8'h00, 8'hF7, {13{8'hBC}}};
        kmask[0] = 16'h0007; kmask[1] = 16'h0000; kmask[2] = 16'h0005;
        bus.tx_ready = 1'b1;
        for (int c = 0; c < 51; c++) begin
            bus.ts_valid = (c < 3);
            bus.ts = sets[(c < 3) ? c : 0];
            step();
            cyc = c + 1;
            ev = (cyc >= 2 && cyc < 50);
            if (ev) begin
                p = cyc - 2; si = p / 16; i = p % 16;
                nvec++;
                if (bus.tx_valid !== 1'b1 || bus.tx_symbol !== sym_of(sets[si], i) || bus.tx_k !== kmask[si][i]) begin
                    nerr++;
                    $display("FAIL b2b_set%0d_sym%0d got v=%b s=%h k=%b want v=1 s=%h k=%b",
                             si, i, bus.tx_valid, bus.tx_symbol, bus.tx_k, sym_of(sets[si], i), kmask[si][i]);
                end
            end else begin
                nvec++;
                if (bus.tx_valid !== 1'b0) begin nerr++; $display("FAIL b2b_idle_cyc%0d got valid=%b want 0", cyc, bus.tx_valid); end
            end
        end
        exp_sent += 3;
        nvec++; if (bus.ts_sent_cnt !== 16'(exp_sent)) begin nerr++; $display("FAIL b2b_cnt got %0d want %0d", bus.ts_sent_cnt, exp_sent); end
    endtask

    task automatic test_backpressure();
        logic f_last, cur;
        int   nwr, first_full;
        nwr = 0; first_full = -1; f_last = 1'b0;
        bus.tx_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cur = bus.ts_tx_fifo_full;
            if (cur && first_full < 0) first_full = c;
            bus.ts_valid = !f_last;
            bus.ts = mk_set(4'(nwr));
            if (!f_last) nwr++;
            step();
            f_last = cur;
        end
        bus.ts_valid = 1'b0;
        nvec++; if (first_full != 4) begin nerr++; $display("FAIL bp_full_cycle got %0d want 4", first_full); end
        nvec++; if (nwr != 5) begin nerr++; $display("FAIL bp_writes got %0d want 5", nwr); end
        nvec++; if (bus.ts_tx_fifo_full !== 1'b1) begin nerr++; $display("FAIL bp_full_settled got %b want 1", bus.ts_tx_fifo_full); end
        nvec++; if (bus.overflow !== 1'b0) begin nerr++; $display("FAIL bp_ovf got %b want 0", bus.overflow); end
        bus.tx_ready = 1'b1;
        for (int k = 0; k < 80; k++) begin
            nvec++;
            if (bus.tx_valid !== 1'b1 || bus.tx_symbol !== sym_of(mk_set(4'(k / 16)), k % 16) || bus.tx_k !== 1'b0) begin
                nerr++;
                $display("FAIL bp_drain_%0d got v=%b s=%h k=%b want v=1 s=%h k=0",
                         k, bus.tx_valid, bus.tx_symbol, bus.tx_k, sym_of(mk_set(4'(k / 16)), k % 16));
            end
            step();
        end
        exp_sent += 5;
        nvec++; if (bus.tx_valid !== 1'b0) begin nerr++; $display("FAIL bp_end_valid got %b want 0", bus.tx_valid); end
        nvec++; if (bus.ts_sent_cnt !== 16'(exp_sent)) begin nerr++; $display("FAIL bp_cnt got %0d want %0d", bus.ts_sent_cnt, exp_sent); end
    endtask

    task automatic test_stall();
        logic [127:0] s;
        logic [15:0]  kmask;
        logic [15:0]  pat;
        int exp_idx;
        s = {8'hBC, 8'hF7, 8'hF7, 104'h0102030405060708090A0B0C0D};
        kmask = 16'h0007;
        pat = 16'hFFE9;
        exp_idx = 0;
        bus.tx_ready = 1'b1;
        bus.ts = s; bus.ts_valid = 1'b1;
        step();
        bus.ts_valid = 1'b0;
        step();
        for (int c = 0; c < 64 && exp_idx < 16; c++) begin
            bus.tx_ready = (c < 16) ? pat[c] : 1'b1;
            nvec++;
            if (bus.tx_valid !== 1'b1 || bus.tx_symbol !== sym_of(s, exp_idx) || bus.tx_k !== kmask[exp_idx]) begin
                nerr++;
                $display("FAIL stall_c%0d_idx%0d got v=%b s=%h k=%b want v=1 s=%h k=%b",
                         c, exp_idx, bus.tx_valid, bus.tx_symbol, bus.tx_k, sym_of(s, exp_idx), kmask[exp_idx]);
            end
            step();
            if (bus.tx_ready) exp_idx++;
        end
        bus.tx_ready = 1'b1;
        nvec++; if (exp_idx != 16) begin nerr++; $display("FAIL stall_timeout got idx %0d want 16", exp_idx); end
        exp_sent++;
        nvec++; if (bus.tx_valid !== 1'b0) begin nerr++; $display("FAIL stall_end_valid got %b want 0", bus.tx_valid); end
        nvec++; if (bus.ts_sent_cnt !== 16'(exp_sent)) begin nerr++; $display("FAIL stall_cnt got %0d want %0d", bus.ts_sent_cnt, exp_sent); end
    endtask

    task automatic test_flush();
        logic [127:0] a;
        a = mk_set(4'h8);
        bus.tx_ready = 1'b1;
        for (int w = 0; w < 4; w++) begin
            bus.ts = mk_set(4'(8 + w)); bus.ts_valid = 1'b1;
            step();
        end
        bus.ts_valid = 1'b0;
        step(); step(); step();
        nvec++; if (bus.tx_symbol !== sym_of(a, 5)) begin nerr++; $display("FAIL flush_pre_idx5 got %h want %h", bus.tx_symbol, sym_of(a, 5)); end
        bus.flush = 1'b1;
        bus.ts = mk_set(4'hE); bus.ts_valid = 1'b1;
        step();
        bus.flush = 1'b0; bus.ts_valid = 1'b0;
        for (int i = 6; i < 16; i++) begin
            nvec++;
            if (bus.tx_valid !== 1'b1 || bus.tx_symbol !== sym_of(a, i)) begin
                nerr++;
                $display("FAIL flush_finish_sym%0d got v=%b s=%h want v=1 s=%h", i, bus.tx_valid, bus.tx_symbol, sym_of(a, i));
            end
            step();
        end
        for (int c = 0; c < 6; c++) begin
            nvec++;
            if (bus.tx_valid !== 1'b0) begin nerr++; $display("FAIL flush_idle_c%0d got valid=%b s=%h want 0", c, bus.tx_valid, bus.tx_symbol); end
            step();
        end
        exp_sent++;
        nvec++; if (bus.ts_sent_cnt !== 16'(exp_sent)) begin nerr++; $display("FAIL flush_cnt got %0d want %0d", bus.ts_sent_cnt, exp_sent); end
        nvec++; if (bus.overflow !== 1'b0) begin nerr++; $display("FAIL flush_ovf got %b want 0", bus.overflow); end
        nvec++; if (bus.ts_tx_fifo_full !== 1'b0) begin nerr++; $display("FAIL flush_full got %b want 0", bus.ts_tx_fifo_full); end
    endtask

    task automatic test_overflow_reset();
        bus.tx_ready = 1'b0;
        for (int w = 0; w < 6; w++) begin
            if (w == 5) begin
                nvec++; if (bus.overflow !== 1'b0) begin nerr++; $display("FAIL ovf_before got %b want 0", bus.overflow); end
            end
            bus.ts = mk_set(4'(w)); bus.ts_valid = 1'b1;
            step();
        end
        bus.ts_valid = 1'b0;
        nvec++; if (bus.overflow !== 1'b1) begin nerr++; $display("FAIL ovf_set got %b want 1", bus.overflow); end
        step(); step(); step();
        nvec++; if (bus.overflow !== 1'b1) begin nerr++; $display("FAIL ovf_sticky got %b want 1", bus.overflow); end
        bus.tx_ready = 1'b1;
        for (int c = 0; c < 7; c++) step();
        nvec++; if (bus.tx_symbol !== 8'h07) begin nerr++; $display("FAIL ovf_idx7 got %h want 07", bus.tx_symbol); end
        rst = 1'b1;
        step();
        nvec++; if (bus.tx_valid !== 1'b0 || bus.tx_symbol !== 8'h00 || bus.tx_k !== 1'b0) begin
            nerr++; $display("FAIL rst_mid_outputs got v=%b s=%h k=%b want 0 00 0", bus.tx_valid, bus.tx_symbol, bus.tx_k);
        end
        nvec++; if (bus.ts_sent_cnt !== 16'd0) begin nerr++; $display("FAIL rst_mid_cnt got %0d want 0", bus.ts_sent_cnt); end
        nvec++; if (bus.overflow !== 1'b0) begin nerr++; $display("FAIL rst_mid_ovf got %b want 0", bus.overflow); end
        nvec++; if (bus.ts_tx_fifo_full !== 1'b0) begin nerr++; $display("FAIL rst_mid_full got %b want 0", bus.ts_tx_fifo_full); end
        rst = 1'b0;
        exp_sent = 0;
        for (int c = 0; c < 20; c++) step();
        nvec++; if (bus.tx_valid !== 1'b0) begin nerr++; $display("FAIL rst_after_valid got %b want 0", bus.tx_valid); end
        nvec++; if (bus.ts_sent_cnt !== 16'(exp_sent)) begin nerr++; $display("FAIL rst_after_cnt got %0d want 0", bus.ts_sent_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_set();
        test_back_to_back();
        test_backpressure();
        test_stall();
        test_flush();
        test_overflow_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout after %0d vectors", nvec);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ts_tx_serializer.md
Name: ts_tx_serializer

Overview:
TX buffer and serializer that consumes 128-bit ordered sets from the TS generator and emits them one 8-bit symbol per accepted cycle toward the lane encoder/SerDes.
- Small FIFO of whole ordered sets; back-pressures the generator through ts_tx_fifo_full.
- Serializes each entry symbol 0 first (bits [127:120]) through symbol 15 (bits [7:0]), tagging control (K) symbols.
- Sits between the TS generator and the 8b/10b encoder; also reports a count of completed ordered sets.

Parameters:
DEPTH, 4, FIFO capacity in 128-bit entries (power of 2, >=2)
FULL_MARGIN, 1, entries of slack before full is raised; covers the generator's 1-cycle valid latency
COM_SYM, 8'hBC, value tagged K at symbol 0
PAD_SYM, 8'hF7, value tagged K at symbols 1-2

Ports:
clk  in  1  1 GHz system clock
rst  in  1  synchronous reset, active-high
ts_valid  in  1  write strobe; one ordered set per cycle when high
ts  in  128  ordered set; symbol 0 = [127:120] ... symbol 15 = [7:0]
ts_tx_fifo_full  out  1  back-pressure to generator
flush  in  1  discard all queued (not yet started) ordered sets
tx_ready  in  1  downstream accepts tx_symbol this cycle
tx_valid  out  1  tx_symbol/tx_k valid
tx_symbol  out  8  current symbol
tx_k  out  1  1 = control symbol
ts_sent_cnt  out  16  completed ordered sets, wraps at 16'hFFFF->0
overflow  out  1  sticky: write attempted while count==DEPTH

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. All outputs 0; FIFO empty; serializer in IDLE; symbol index 0; ts_sent_cnt 0; overflow 0.
  - Reset mid-ordered-set discards the partial set; no completion is counted.
- FIFO:
  - count register, range 0..DEPTH. Write pointer and read pointer are log2(DEPTH) bits and wrap naturally.
  - ts_tx_fifo_full = (count >= DEPTH-FULL_MARGIN). This is a combinational decode of the count register, with no further latency.
  - A write when count==DEPTH is dropped and sets overflow (sticky until rst). It is never written over the head.
  - A write and a pop in the same cycle leave count unchanged; both take effect.
- Serializer FSM:
  - IDLE:
    - tx_valid=0, tx_symbol=0, tx_k=0.
    - If count!=0, load the head entry into a 128-bit shift register, pop it, set idx=0, and go to SEND.
  - SEND:
    - tx_valid=1. tx_symbol = shift_reg[127:120].
    - tx_k = 1 if (idx==0 and symbol==COM_SYM), or (idx in {1,2} and symbol==PAD_SYM); otherwise 0.
    - If tx_ready: shift left 8 and idx++.
    - If tx_ready and idx==15:
      - ts_sent_cnt increments.
      - If count!=0 (evaluated that cycle, including an entry written previously), load the next entry and pop with idx=0, staying in SEND. Back-to-back sets have no bubble.
      - Otherwise go to IDLE.
    - If !tx_ready: hold all outputs stable; no advance.
- Latency: a write at cycle N is visible in count at N+1. From IDLE, tx_valid rises at N+2 with symbol 0.
- flush:
  - Sets count=0 and rd_ptr=wr_ptr.
  - A write in the same cycle is dropped, with no overflow.
  - A pop in the same cycle still loads its entry.
  - The ordered set currently in SEND always completes, to preserve symbol alignment.
- tx_ready is ignored in IDLE.
- ts_sent_cnt wraps silently.

Test Plan:
- Single set: write ts=BC F7 F7 FF 02 00 4A×10 with tx_ready=1 -> tx_valid rises 2 cycles after the write. Symbols emitted in order; tx_k=1 on the first three only; tx_valid falls after 16 cycles; ts_sent_cnt=1.
- Back-to-back: generator writes 3 sets on consecutive cycles, tx_ready=1 -> 48 contiguous tx_valid cycles with no bubble; ts_sent_cnt=3.
- Back-pressure: DEPTH=4, tx_ready=0, ts_valid held high and gated by full with 1-cycle latency -> full at count=3; count settles at 4; overflow stays 0; no set is lost after tx_ready returns.
- Stall: tx_ready toggles 1,0,0,1 mid-set -> symbol and tx_k held during stalls; no symbol skipped or duplicated.
- Flush: 3 sets queued, serializer at idx=5, flush pulse -> current set finishes (11 more symbols), then IDLE; ts_sent_cnt +1 only; queued sets never appear.
- Overflow and reset: force ts_valid while count==4 -> overflow=1 sticky. Then rst at idx=7 -> all outputs 0 next cycle; ts_sent_cnt=0; overflow=0.
